regfile_dump_tx: RTL and testbench

//  Downstream consumer of the register file's flat regfilePort bus. On request it snapshots all

---
 rtl/narvie_dump_pkg.sv | 13 +
 rtl/regfile_dump_tx.sv | 93 +++++++++
 tb/tb_regfile_dump_tx.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/narvie_dump_pkg.sv
// Shared definitions for the register-file dump frame, used by the transmitter and by host-side models.
package narvie_dump_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2,
    CSUM = 2'd3
  } dumpState_t;

  localparam logic [7:0] DEFAULT_FRAME_HDR = 8'hA5;

endpackage

// File: rtl/regfile_dump_tx.sv
// Snapshots the flat register-file image and streams it as header, little-endian data bytes, XOR checksum
// over a valid/ready byte link to the UART transmitter.
module regfile_dump_tx
  import narvie_dump_pkg::*;
#(
  parameter int         NUM_REGS  = 32,
  parameter int         XLEN      = 32,
  parameter logic [7:0] FRAME_HDR = DEFAULT_FRAME_HDR
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     dump_req,
  input  logic [NUM_REGS*XLEN-1:0] regfile_port,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic                     busy,
  output logic                     done
);

  localparam int IMG_W  = NUM_REGS * XLEN;
  localparam int NBYTES = IMG_W / 8;
  localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES - 1);

  dumpState_t       state;
  logic [IMG_W-1:0] shadow;
  logic [IMG_W-1:0] shadowNext;
  logic [CNT_W-1:0] byteCnt;
  logic [7:0]       checksum;
  logic             accept;

  // The shadow only ever shifts right, so the byte on the wire is always its lowest byte.
  assign shadowNext = shadow >> 8;
  assign accept     = tx_valid && tx_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      byteCnt  <= '0;
      checksum <= 8'h00;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (dump_req) begin
            shadow   <= regfile_port;
            checksum <= 8'h00;
            byteCnt  <= '0;
            tx_data  <= FRAME_HDR;
            tx_valid <= 1'b1;
            busy     <= 1'b1;
            state    <= HDR;
          end
        end
        HDR: begin
          if (accept) begin
            tx_data <= shadow[7:0];
            state   <= DATA;
          end
        end
        DATA: begin
          if (accept) begin
            checksum <= checksum ^ tx_data;
            shadow   <= shadowNext;
            // The counter parks on the last index instead of wrapping to zero.
            if (byteCnt == LAST_BYTE) begin
              tx_data <= checksum ^ tx_data;
              state   <= CSUM;
            end else begin
              byteCnt <= byteCnt + 1'b1;
              tx_data <= shadowNext[7:0];
            end
          end
        end
        CSUM: begin
          if (accept) begin
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_tx.sv
// Directed bench for regfile_dump_tx: frame contents, stalls, capture isolation, back-to-back and reset.
module tb_regfile_dump_tx;
  import narvie_dump_pkg::*;

  localparam int NB = 128;
  localparam int L  = NB + 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         dump_req;
  logic [1023:0] regfile_port;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic         busy;
  logic         done;

  int passed = 0;
  int total  = 0;

  logic [7:0] got[$];
  logic [7:0] expq[$];
  int doneCyc, busyLowCyc, stallErr, readyPct, mutateAt;
  logic [31:0] mutateVal;

  always #5 clk = ~clk;

  regfile_dump_tx dut (
    .clk          (clk),
    .reset        (reset),
    .dump_req     (dump_req),
    .regfile_port (regfile_port),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .busy         (busy),
    .done         (done)
  );

  // Host-side frame model: header, x0..x31 little-endian, XOR of data bytes.
  function automatic void buildExpected(input logic [1023:0] img);
    logic [7:0] cs;
    cs = 8'h00;
    expq.delete();
    expq.push_back(DEFAULT_FRAME_HDR);
    for (int i = 0; i < NB; i++) begin
      expq.push_back(img[8*i +: 8]);
      cs = cs ^ img[8*i +: 8];
    end
    expq.push_back(cs);
  endfunction

  function automatic int countDiffs();
    int bad;
    bad = 0;
    if (got.size() != expq.size()) return 9999;
    for (int i = 0; i < got.size(); i++)
      if (got[i] !== expq[i]) bad++;
    return bad;
  endfunction

  task automatic startFrame();
    dump_req = 1'b1;
    @(posedge clk); #1;
    dump_req = 1'b0;
  endtask

  // Collects accepted bytes from cycle 1 until done or the budget runs out.
  task automatic collect(input int budget);
    logic pv, pr;
    logic [7:0] pd;
    got.delete();
    doneCyc = -1; busyLowCyc = -1; stallErr = 0;
    pv = 1'b0; pr = 1'b0; pd = 8'h00;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      if (busy === 1'b0 && busyLowCyc < 0) busyLowCyc = cyc;
      if (pv && !pr && (tx_valid !== 1'b1 || tx_data !== pd)) stallErr++;
      if (done === 1'b1) begin
        doneCyc = cyc;
        break;
      end
      if (mutateAt >= 0 && got.size() == mutateAt) begin
        regfile_port[63:32] = mutateVal;
        mutateAt = -1;
      end
      tx_ready = ($urandom_range(99) >= readyPct) ? 1'b1 : 1'b0;
      if (tx_valid === 1'b1 && tx_ready) got.push_back(tx_data);
      pv = tx_valid; pr = tx_ready; pd = tx_data;
      @(posedge clk); #1;
    end
    tx_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; dump_req = 1'b0; tx_ready = 1'b0; regfile_port = '0;
    readyPct = 0; mutateAt = -1; mutateVal = 32'h0;
    #2;
    total++; if (tx_valid !== 1'b0) $display("FAIL reset_tx_valid got=%b want=0", tx_valid); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done got=%b want=0", done); else passed++;
    total++; if (tx_data !== 8'h00) $display("FAIL reset_tx_data got=%h want=00", tx_data); else passed++;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_frame();
    regfile_port = '0;
    regfile_port[63:32] = 32'h11223344;
    buildExpected(regfile_port);
    readyPct = 0;
    startFrame();
    total++; if (tx_valid !== 1'b1 || tx_data !== 8'hA5)
      $display("FAIL basic_first got valid=%b data=%h want valid=1 data=a5", tx_valid, tx_data); else passed++;
    collect(1000);
    total++; if (countDiffs() != 0 || got.size() != L)
      $display("FAIL basic_frame len=%0d diffs=%0d want len=%0d diffs=0", got.size(), countDiffs(), L); else passed++;
    total++; if (got.size() == L && {got[5], got[6], got[7], got[8]} !== 32'h44332211)
      $display("FAIL basic_x1_bytes got=%h%h%h%h want=44332211", got[5], got[6], got[7], got[8]); else passed++;
    total++; if (got.size() == L && got[L-1] !== 8'h44)
      $display("FAIL basic_checksum got=%h want=44", got[L-1]); else passed++;
    total++; if (doneCyc != 131) $display("FAIL basic_done_cycle got=%0d want=131", doneCyc); else passed++;
    total++; if (busyLowCyc != 131) $display("FAIL basic_busy_low got=%0d want=131", busyLowCyc); else passed++;
    @(posedge clk); #1;
    total++; if (done !== 1'b0) $display("FAIL basic_done_width got=%b want=0", done); else passed++;
  endtask

  task automatic test_stall();
    regfile_port = '0;
    regfile_port[63:32] = 32'h11223344;
    buildExpected(regfile_port);
    readyPct = 30;
    startFrame();
    collect(2000);
    readyPct = 0;
    total++; if (countDiffs() != 0 || got.size() != L)
      $display("FAIL stall_frame len=%0d diffs=%0d want len=%0d diffs=0", got.size(), countDiffs(), L); else passed++;
    total++; if (stallErr != 0) $display("FAIL stall_hold violations=%0d want=0", stallErr); else passed++;
    total++; if (doneCyc < 131) $display("FAIL stall_done got=%0d want>=131", doneCyc); else passed++;
  endtask

  task automatic test_capture();
    regfile_port = '0;
    regfile_port[63:32] = 32'h11223344;
    buildExpected(regfile_port);
    mutateAt = 3; mutateVal = 32'hDEADBEEF;
    startFrame();
    collect(1000);
    total++; if (countDiffs() != 0)
      $display("FAIL capture_isolated diffs=%0d want=0", countDiffs()); else passed++;
    startFrame();
    collect(1000);
    total++; if (got.size() != L || {got[5], got[6], got[7], got[8]} !== 32'hEFBEADDE)
      $display("FAIL capture_next got=%h%h%h%h want=efbeadde", got[5], got[6], got[7], got[8]); else passed++;
  endtask

  task automatic test_back_to_back();
    int doneQ[$];
    int nacc, accAt262;
    logic v131, v132;
    regfile_port = '0;
    regfile_port[63:32] = 32'h11223344;
    tx_ready = 1'b1; nacc = 0; accAt262 = -1; v131 = 1'bx; v132 = 1'bx;
    dump_req = 1'b1;
    @(posedge clk); #1;
    for (int cyc = 1; cyc <= 265; cyc++) begin
      if (done === 1'b1) doneQ.push_back(cyc);
      if (cyc == 131) v131 = tx_valid;
      if (cyc == 132) v132 = tx_valid;
      if (tx_valid === 1'b1 && tx_ready) nacc++;
      if (cyc == 262) accAt262 = nacc;
      @(posedge clk); #1;
    end
    dump_req = 1'b0;
    collect(400);
    total++; if (doneQ.size() != 2 || doneQ[0] != 131 || doneQ[1] != 262)
      $display("FAIL b2b_done count=%0d first=%0d want 2 pulses at 131,262", doneQ.size(),
               (doneQ.size() > 0) ? doneQ[0] : -1); else passed++;
    total++; if (v131 !== 1'b0 || v132 !== 1'b1)
      $display("FAIL b2b_gap got v131=%b v132=%b want 0,1", v131, v132); else passed++;
    total++; if (accAt262 != 2 * L)
      $display("FAIL b2b_bytes got=%0d want=%0d", accAt262, 2 * L); else passed++;
    total++; if (doneCyc < 0) $display("FAIL b2b_drain got=%0d want done", doneCyc); else passed++;
  endtask

  task automatic test_reset_midframe();
    logic sawDone;
    regfile_port = '0;
    regfile_port[63:32] = 32'h11223344;
    tx_ready = 1'b1;
    startFrame();
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    #1;
    total++; if (tx_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL rst_mid_immediate got valid=%b busy=%b want 0,0", tx_valid, busy); else passed++;
    sawDone = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (done !== 1'b0) sawDone = 1'b1;
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || tx_valid !== 1'b0) sawDone = 1'b1;
    end
    total++; if (sawDone) $display("FAIL rst_mid_quiet got activity=1 want=0"); else passed++;
    buildExpected(regfile_port);
    startFrame();
    collect(1000);
    total++; if (got.size() != L || got[0] !== 8'hA5 || countDiffs() != 0)
      $display("FAIL rst_mid_restart len=%0d diffs=%0d want len=%0d diffs=0", got.size(), countDiffs(), L); else passed++;
  endtask

  task automatic test_x31();
    regfile_port = '0;
    regfile_port[1023:992] = 32'hFFFFFFFF;
    buildExpected(regfile_port);
    startFrame();
    collect(1000);
    total++; if (got.size() != L || {got[125], got[126], got[127], got[128]} !== 32'hFFFFFFFF)
      $display("FAIL x31_bytes len=%0d want FFFFFFFF in last data bytes", got.size()); else passed++;
    total++; if (got.size() != L || got[L-1] !== 8'h00)
      $display("FAIL x31_checksum got=%h want=00", (got.size() == L) ? got[L-1] : 8'hxx); else passed++;
    total++; if (countDiffs() != 0) $display("FAIL x31_frame diffs=%0d want=0", countDiffs()); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_stall();
    test_capture();
    test_back_to_back();
    test_reset_midframe();
    test_x31();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
